// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer width and gray-code conversion.
// The conversion functions work on a fixed wide vector; callers zero-extend
// their pointer into it and truncate the result, which is exact for both
// directions because the unused upper bits stay zero.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    // Pointers carry one extra wrap bit above the RAM index.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer entering a new clock domain.
// Only one bit of the pointer changes per source cycle, so a plain flop chain
// is safe here; the chain clears with the destination reset.
module fifo_gray_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clock_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the foreign pointer through STAGES flops in the local clock domain.
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_flags.sv
// Dual-clock first-word-fall-through FIFO with almost-full/almost-empty flags,
// per-domain fill levels and a write-overflow pulse. Binary pointers drive the
// RAM and level arithmetic; only gray copies cross between clock domains.
// Each side computes its level against a stale view of the other pointer, so
// the write level can only over-count and the read level can only under-count.
module async_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 4,
    parameter int SYNC_STAGES      = 2,
    parameter int ALMOST_FULL_LVL  = 12,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clock_in,
    input  logic                  rst_in_n,
    input  logic                  clock_out,
    input  logic                  rst_out_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_full,
    output logic                  data_in_almost_full,
    output logic [ADDR_WIDTH:0]   data_in_level,
    output logic                  data_in_overflow,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ack,
    output logic                  data_out_almost_empty,
    output logic [ADDR_WIDTH:0]   data_out_level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);
    localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

    // Storage: written in the write domain, read combinationally for FWFT.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write-domain state.
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic [PW-1:0] rgray_sync;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;

    // Read-domain state.
    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic [PW-1:0] wgray_sync;
    logic          valid_q, valid_d;
    logic          aempty_q, aempty_d;
    logic          pop;

    // Write pointer crossing into the read domain.
    fifo_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clock_i (clock_out),
        .rst_n_i (rst_out_n),
        .d_i     (wgray_q),
        .q_o     (wgray_sync)
    );

    // Read pointer crossing into the write domain.
    fifo_gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clock_i (clock_in),
        .rst_n_i (rst_in_n),
        .d_i     (rgray_q),
        .q_o     (rgray_sync)
    );

    // Write side next state: advance on accepted word, derive full/level/flags.
    always_comb begin
        wr_en    = data_in_valid && !full_q;
        wbin_d   = wbin_q + PW'(wr_en);
        wgray_d  = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
        full_d   = (wgray_d == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});
        wlevel_d = wbin_d - PW'(gray2bin(GRAY_MAX_W'(rgray_sync)));
        afull_d  = (wlevel_d >= AF_LVL);
        ovf_d    = data_in_valid && full_q;
    end

    // Write side registers.
    always_ff @(posedge clock_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // RAM write port; contents are deliberately left out of reset.
    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Read side next state: pop the head when acknowledged while valid.
    always_comb begin
        pop      = data_out_ack && valid_q;
        rbin_d   = rbin_q + PW'(pop);
        rgray_d  = PW'(bin2gray(GRAY_MAX_W'(rbin_d)));
        valid_d  = (rgray_d != wgray_sync);
        rlevel_d = PW'(gray2bin(GRAY_MAX_W'(wgray_sync))) - rbin_d;
        aempty_d = (rlevel_d <= AE_LVL);
    end

    // Read side registers.
    always_ff @(posedge clock_out or negedge rst_out_n) begin
        if (!rst_out_n) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rlevel_q <= '0;
            valid_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rlevel_q <= rlevel_d;
            valid_q  <= valid_d;
            aempty_q <= aempty_d;
        end
    end

    assign data_in_full          = full_q;
    assign data_in_almost_full   = afull_q;
    assign data_in_level         = wlevel_q;
    assign data_in_overflow      = ovf_q;
    assign data_out              = mem_q[rbin_q[ADDR_WIDTH-1:0]];
    assign data_out_valid        = valid_q;
    assign data_out_almost_empty = aempty_q;
    assign data_out_level        = rlevel_q;

endmodule

// File: tb/tb_async_fifo_flags.sv
// Bench for async_fifo_flags: directed scenarios plus a long randomized
// two-clock run, all checked against a queue model of the FIFO contents and
// the level/flag rules stated in terms of true occupancy.
// Time unit is 100 ps: clock_in 10 ns (100 MHz), clock_out 27 ns (~37 MHz).
module tb_async_fifo_flags;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;
  localparam int NWORDS = 10000;

  logic          clock_in, rst_in_n, clock_out, rst_out_n;
  logic [DW-1:0] data_in;
  logic          data_in_valid, data_in_full, data_in_almost_full, data_in_overflow;
  logic [AW:0]   data_in_level, data_out_level;
  logic [DW-1:0] data_out;
  logic          data_out_valid, data_out_ack, data_out_almost_empty;

  async_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
    .ALMOST_FULL_LVL(AFL), .ALMOST_EMPTY_LVL(AEL)
  ) dut (
    .clock_in(clock_in), .rst_in_n(rst_in_n), .clock_out(clock_out), .rst_out_n(rst_out_n),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_full(data_in_full),
    .data_in_almost_full(data_in_almost_full), .data_in_level(data_in_level),
    .data_in_overflow(data_in_overflow), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ack(data_out_ack), .data_out_almost_empty(data_out_almost_empty),
    .data_out_level(data_out_level)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock_in = 1'b0;
    forever #50 clock_in = ~clock_in;
  end

  initial begin
    clock_out = 1'b0;
    #25;
    forever begin
      clock_out = 1'b1;
      #135;
      clock_out = 1'b0;
      #135;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int  vec_cnt = 0;
  int  err_cnt = 0;
  int  wr_cnt = 0;     // words accepted (counted just before their write edge)
  int  rd_cnt = 0;     // words popped (counted just before their pop edge)
  int  ovf_seen = 0;
  bit  drop_prev = 1'b0;
  bit  mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write-side monitor: overflow timing, flag rules, pessimistic level bound, model push.
  always @(negedge clock_in) begin
    if (mon_en) begin
      check("overflow", 32'(data_in_overflow), 32'(drop_prev));
      if (data_in_overflow) ovf_seen++;
      check("full_rule", 32'(data_in_full), 32'(int'(data_in_level) == DEPTH));
      check("afull_rule", 32'(data_in_almost_full), 32'(int'(data_in_level) >= AFL));
      check("wlevel_bound",
            32'((int'(data_in_level) >= wr_cnt - rd_cnt) && (int'(data_in_level) <= DEPTH)), 32'd1);
      drop_prev = data_in_valid && data_in_full;
      if (data_in_valid && !data_in_full) begin
        exp_q.push_back(data_in);
        wr_cnt++;
      end
    end
  end

  // Read-side monitor: flag rules, pessimistic level bound, data vs model.
  always @(negedge clock_out) begin
    if (mon_en) begin
      check("valid_rule", 32'(data_out_valid), 32'(int'(data_out_level) != 0));
      check("aempty_rule", 32'(data_out_almost_empty), 32'(int'(data_out_level) <= AEL));
      check("rlevel_bound", 32'(int'(data_out_level) <= wr_cnt - rd_cnt), 32'd1);
      if (data_out_ack && data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("underflow", 32'd1, 32'd0);
        end else begin
          check("data", data_out, exp_q.pop_front());
        end
        rd_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    data_in_valid = 1'b0;
    data_out_ack = 1'b0;
    @(negedge clock_in);
    #10;
    rst_in_n = 1'b0;
    rst_out_n = 1'b0;
    repeat (4) @(posedge clock_out);
    #10;
    check("rst_full", 32'(data_in_full), 32'd0);
    check("rst_afull", 32'(data_in_almost_full), 32'd0);
    check("rst_wlevel", 32'(data_in_level), 32'd0);
    check("rst_ovf", 32'(data_in_overflow), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_aempty", 32'(data_out_almost_empty), 32'd1);
    check("rst_rlevel", 32'(data_out_level), 32'd0);
    exp_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    drop_prev = 1'b0;
    @(negedge clock_in);
    #10;
    rst_in_n = 1'b1;
    rst_out_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    @(posedge clock_in);
    #10;
    data_in = d;
    data_in_valid = 1'b1;
    @(posedge clock_in);
    #10;
    data_in_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(posedge clock_out);
    #10;
    data_out_ack = 1'b1;
    @(posedge clock_out);
    #10;
    data_out_ack = 1'b0;
  endtask

  task automatic wait_out(input int n);
    repeat (n) @(posedge clock_out);
    #10;
  endtask

  task automatic wait_in(input int n);
    repeat (n) @(posedge clock_in);
    #10;
  endtask

  task automatic drain();
    int guard = 0;
    @(posedge clock_out);
    #10;
    data_out_ack = 1'b1;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clock_out);
      #10;
      guard++;
    end
    data_out_ack = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    wait_in(SS + 4);
    check("drain_wlevel", 32'(data_in_level), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int base_w, base_r;
    rst_in_n = 1'b0;
    rst_out_n = 1'b0;
    data_in = '0;
    data_in_valid = 1'b0;
    data_out_ack = 1'b0;
    do_reset();

    // 1: single word latency and FWFT head.
    @(posedge clock_in);
    #10;
    data_in = 32'hA5A5_0001;
    data_in_valid = 1'b1;
    @(posedge clock_in);
    #10;
    data_in_valid = 1'b0;
    n = 0;
    while (n < 12 && !data_out_valid) begin
      @(posedge clock_out);
      #10;
      n++;
    end
    check("t1_latency", 32'(n), 32'(SS + 1));
    check("t1_head", data_out, 32'hA5A5_0001);
    pop_one();
    check("t1_valid_after_ack", 32'(data_out_valid), 32'd0);
    check("t1_aempty_after_ack", 32'(data_out_almost_empty), 32'd1);
    wait_in(SS + 4);

    // 2: fill to full, overflow pulse, ordered readback.
    for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
    check("t2_full", 32'(data_in_full), 32'd1);
    check("t2_wlevel", 32'(data_in_level), 32'(DEPTH));
    write_word(32'hDEAD_BEEF);
    check("t2_ovf_pulse", 32'(data_in_overflow), 32'd1);
    wait_in(1);
    check("t2_ovf_clear", 32'(data_in_overflow), 32'd0);
    check("t2_wlevel_kept", 32'(data_in_level), 32'(DEPTH));
    wait_out(SS + 2);
    check("t2_rlevel", 32'(data_out_level), 32'(DEPTH));
    drain();

    // 3: almost-full and almost-empty thresholds.
    for (int i = 0; i < AFL - 1; i++) write_word($urandom);
    check("t3_wlevel_11", 32'(data_in_level), 32'(AFL - 1));
    check("t3_afull_11", 32'(data_in_almost_full), 32'd0);
    write_word($urandom);
    check("t3_afull_12", 32'(data_in_almost_full), 32'd1);
    wait_out(SS + 2);
    check("t3_rlevel_12", 32'(data_out_level), 32'(AFL));
    pop_one();
    wait_in(SS + 3);
    check("t3_wlevel_back_11", 32'(data_in_level), 32'(AFL - 1));
    check("t3_afull_back_11", 32'(data_in_almost_full), 32'd0);
    for (int i = 0; i < AFL - 1 - (AEL + 1); i++) pop_one();
    check("t3_rlevel_3", 32'(data_out_level), 32'(AEL + 1));
    check("t3_aempty_3", 32'(data_out_almost_empty), 32'd0);
    pop_one();
    check("t3_rlevel_2", 32'(data_out_level), 32'(AEL));
    check("t3_aempty_2", 32'(data_out_almost_empty), 32'd1);
    drain();

    // 5: full FIFO, one pop frees space within the sync latency.
    for (int i = 0; i < DEPTH; i++) write_word($urandom);
    wait_out(SS + 2);
    pop_one();
    n = 0;
    while (n < 20 && data_in_full) begin
      @(posedge clock_in);
      #10;
      n++;
    end
    check("t5_full_release", 32'(n <= SS + 2), 32'd1);
    write_word(32'h5555_AAAA);
    check("t5_refill_full", 32'(data_in_full), 32'd1);
    check("t5_no_ovf", 32'(data_in_overflow), 32'd0);
    drain();

    // 4: randomized two-clock streaming.
    base_w = wr_cnt;
    base_r = rd_cnt;
    ovf_seen = 0;
    fork
      begin
        int guard = 0;
        forever begin
          @(posedge clock_in);
          #10;
          if (wr_cnt - base_w >= NWORDS || guard > 60000) break;
          data_in = $urandom;
          data_in_valid = !data_in_full && ($urandom_range(0, 99) < 60);
          guard++;
        end
        data_in_valid = 1'b0;
      end
      begin
        int guard = 0;
        forever begin
          @(posedge clock_out);
          #10;
          if (rd_cnt - base_r >= NWORDS || guard > 30000) break;
          data_out_ack = ($urandom_range(0, 99) < 80);
          guard++;
        end
        data_out_ack = 1'b0;
      end
    join
    check("t4_written", 32'(wr_cnt - base_w), 32'(NWORDS));
    check("t4_read", 32'(rd_cnt - base_r), 32'(NWORDS));
    check("t4_no_overflow", 32'(ovf_seen), 32'd0);
    check("t4_wraps", 32'((wr_cnt - base_w) / (2 * DEPTH) >= 2), 32'd1);
    check("t4_model_empty", 32'(exp_q.size()), 32'd0);

    // 6: reset both domains with 8 words queued, then reuse.
    wait_in(SS + 4);
    for (int i = 0; i < 8; i++) write_word($urandom);
    wait_out(SS + 2);
    check("t6_rlevel_8", 32'(data_out_level), 32'd8);
    do_reset();
    wait_out(SS + 2);
    check("t6_valid_post", 32'(data_out_valid), 32'd0);
    for (int i = 0; i < 5; i++) write_word(32'hC0DE_0000 + DW'(i));
    wait_out(SS + 2);
    check("t6_rlevel_5", 32'(data_out_level), 32'd5);
    check("t6_head", data_out, 32'hC0DE_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
